// File: rtl/ether_in_if.sv
// ether_in_if: RMII receive dibit stream in, payload dibits and frame status out.
interface ether_in_if;
  logic        axiiv;
  logic [1:0]  axiid;
  logic        axiov;
  logic [1:0]  axiod;
  logic        header_valid;
  logic [47:0] dest_mac;
  logic [47:0] src_mac;
  logic [15:0] ethertype;
  logic        frame_done;
  logic        fcs_ok;
  modport master(output axiiv, axiid,
                 input axiov, axiod, header_valid, dest_mac, src_mac, ethertype, frame_done, fcs_ok);
  modport slave(input axiiv, axiid,
                output axiov, axiod, header_valid, dest_mac, src_mac, ethertype, frame_done, fcs_ok);
endinterface

// File: rtl/ether_in.sv
// ether_in: RMII frame receiver; preamble/SFD sync, header capture, FCS-stripped payload, CRC-32 check.
module ether_in #(
  parameter logic [47:0] MAC_ADDR     = 48'hFFFF_FFFF_FFFF,
  parameter int          MIN_PREAMBLE = 8
) (
  input logic        clk,
  input logic        rst,
  ether_in_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RECEIVE, CHECK} state_t;
  state_t             state_q, state_d;
  logic [4:0]         pre_cnt_q, pre_cnt_d;
  logic [12:0]        rx_cnt_q, rx_cnt_d;
  logic [15:0][1:0]   dl_q, dl_d;
  logic [31:0]        crc_q, crc_d;
  logic [109:0]       sr_q, sr_d;
  logic [111:0]       hdr_q, hdr_d;
  logic               addr_ok_q, addr_ok_d;
  logic               hv_q, hv_d;
  logic               ov_q, ov_d;
  logic [1:0]         od_q, od_d;
  logic               done_q, done_d;
  logic               fcs_q, fcs_d;
  logic [111:0]       hdr_new;

  function automatic logic [31:0] crc_bit(logic [31:0] c, logic b);
    return {c[30:0], 1'b0} ^ ((c[31] ^ b) ? 32'h04C1_1DB7 : 32'h0);
  endfunction

  // oldest delay-line dibit completes the header when it is popped dibit 55
  assign hdr_new = {sr_q, dl_q[15]};

  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    rx_cnt_d  = rx_cnt_q;
    dl_d      = dl_q;
    crc_d     = crc_q;
    sr_d      = sr_q;
    hdr_d     = hdr_q;
    addr_ok_d = addr_ok_q;
    hv_d      = 1'b0;
    ov_d      = 1'b0;
    od_d      = 2'b00;
    done_d    = 1'b0;
    fcs_d     = fcs_q;
    if (state_q == IDLE) begin
      pre_cnt_d = (bus.axiiv && bus.axiid == 2'b01) ? ((&pre_cnt_q) ? pre_cnt_q : pre_cnt_q + 5'd1) : 5'd0;
      if (bus.axiiv && bus.axiid == 2'b11 && 32'(pre_cnt_q) >= MIN_PREAMBLE) begin
        state_d   = RECEIVE;
        crc_d     = '1;
        rx_cnt_d  = '0;
        dl_d      = '0;
        addr_ok_d = 1'b0;
      end
    end else if (state_q == RECEIVE) begin
      if (!bus.axiiv) begin
        state_d = CHECK;
        done_d  = 1'b1;
        fcs_d   = rx_cnt_q >= 13'd72 && rx_cnt_q[1:0] == 2'b00 && ~crc_q == dl_q;
      end else begin
        dl_d     = {dl_q[14:0], bus.axiid};
        rx_cnt_d = (&rx_cnt_q) ? rx_cnt_q : rx_cnt_q + 13'd1;
        if (rx_cnt_q >= 13'd16) begin
          crc_d = crc_bit(crc_bit(crc_q, dl_q[15][1]), dl_q[15][0]);
          sr_d  = (rx_cnt_q < 13'd71) ? hdr_new[109:0] : sr_q;
          if (rx_cnt_q == 13'd71) begin
            hdr_d     = hdr_new;
            hv_d      = 1'b1;
            addr_ok_d = hdr_new[111:64] == MAC_ADDR || hdr_new[111:64] == '1;
          end
          ov_d = rx_cnt_q > 13'd71 && addr_ok_q;
          od_d = ov_d ? dl_q[15] : 2'b00;
        end
      end
    end else begin
      state_d   = IDLE;
      pre_cnt_d = '0;
      rx_cnt_d  = '0;
      dl_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pre_cnt_q <= '0;
      rx_cnt_q  <= '0;
      dl_q      <= '0;
      crc_q     <= '1;
      sr_q      <= '0;
      hdr_q     <= '0;
      addr_ok_q <= 1'b0;
      hv_q      <= 1'b0;
      ov_q      <= 1'b0;
      od_q      <= 2'b00;
      done_q    <= 1'b0;
      fcs_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      dl_q      <= dl_d;
      crc_q     <= crc_d;
      sr_q      <= sr_d;
      hdr_q     <= hdr_d;
      addr_ok_q <= addr_ok_d;
      hv_q      <= hv_d;
      ov_q      <= ov_d;
      od_q      <= od_d;
      done_q    <= done_d;
      fcs_q     <= fcs_d;
    end
  end

  assign bus.axiov        = ov_q;
  assign bus.axiod        = od_q;
  assign bus.header_valid = hv_q;
  assign bus.dest_mac     = hdr_q[111:64];
  assign bus.src_mac      = hdr_q[63:16];
  assign bus.ethertype    = hdr_q[15:0];
  assign bus.frame_done   = done_q;
  assign bus.fcs_ok       = fcs_q;
endmodule

// File: tb/tb_ether_in.sv
// tb_ether_in: randomized frames checked against a frame-level model of the receiver.
module tb_ether_in;
  typedef logic [1:0] dibit_t;
  typedef dibit_t dq_t[$];
  localparam logic [47:0] MAC   = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  dq_t got_pl;
  int first_ov = -1;
  int hv_n = 0;
  int done_n = 0;
  logic done_fcs = 1'b0;
  logic [47:0] exp_dest = '0;
  logic [47:0] exp_src = '0;
  logic [15:0] exp_eth = '0;
  logic exp_fcs = 1'b0;

  ether_in_if bus();
  ether_in #(.MAC_ADDR(MAC), .MIN_PREAMBLE(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (bus.axiov) begin
      if (got_pl.size() == 0) first_ov = cyc;
      got_pl.push_back(bus.axiod);
    end
    if (bus.header_valid) hv_n = hv_n + 1;
    if (bus.frame_done) begin
      done_n = done_n + 1;
      done_fcs = bus.fcs_ok;
    end
  end

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(string tag);
    chk({tag, " axiov"}, 64'(bus.axiov), 0);
    chk({tag, " axiod"}, 64'(bus.axiod), 0);
    chk({tag, " header_valid"}, 64'(bus.header_valid), 0);
    chk({tag, " dest_mac"}, 64'(bus.dest_mac), 0);
    chk({tag, " src_mac"}, 64'(bus.src_mac), 0);
    chk({tag, " ethertype"}, 64'(bus.ethertype), 0);
    chk({tag, " frame_done"}, 64'(bus.frame_done), 0);
    chk({tag, " fcs_ok"}, 64'(bus.fcs_ok), 0);
  endtask

  // CRC-32, polynomial 04C11DB7, preset all-ones, bits taken MSB of each dibit first, result inverted
  function automatic logic [31:0] fcs_of(dq_t q);
    logic [31:0] c = '1;
    foreach (q[i]) for (int b = 1; b >= 0; b--) begin
      logic fb = c[31] ^ q[i][b];
      c = c << 1;
      if (fb) c = c ^ 32'h04C1_1DB7;
    end
    return ~c;
  endfunction

  function automatic dq_t words(logic [31:0] w);
    dq_t q;
    for (int i = 15; i >= 0; i--) q.push_back(w[2*i +: 2]);
    return q;
  endfunction

  function automatic dq_t rand_dibits(int n);
    dq_t q;
    for (int i = 0; i < n; i++) q.push_back(dibit_t'($urandom_range(0, 3)));
    return q;
  endfunction

  function automatic dq_t build(logic [47:0] dest, logic [47:0] src, logic [15:0] eth, dq_t pl);
    dq_t b;
    logic [31:0] f;
    for (int i = 23; i >= 0; i--) b.push_back(dest[2*i +: 2]);
    for (int i = 23; i >= 0; i--) b.push_back(src[2*i +: 2]);
    for (int i = 7; i >= 0; i--) b.push_back(eth[2*i +: 2]);
    foreach (pl[i]) b.push_back(pl[i]);
    f = fcs_of(b);
    for (int i = 15; i >= 0; i--) b.push_back(f[2*i +: 2]);
    return b;
  endfunction

  task automatic drive(logic v, dibit_t d);
    @(negedge clk);
    bus.axiiv = v;
    bus.axiid = d;
  endtask

  task automatic run_frame(string tag, int pre, dq_t body, int abort_at);
    int n = body.size();
    int eff = n;
    int drv56 = -1;
    bit synced = pre >= 8;
    logic [111:0] h = '0;
    logic [31:0] tail = '0;
    dq_t exp_pl;
    dq_t data;
    bit acc;
    got_pl.delete();
    first_ov = -1;
    hv_n = 0;
    done_n = 0;
    repeat (pre) drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        eff = i;
        @(negedge clk);
        rst = 1'b0;
        bus.axiiv = 1'b0;
        #1;
        chk_zero({tag, " in reset"});
        repeat (3) @(negedge clk);
        rst = 1'b1;
        break;
      end
      drive(1'b1, body[i]);
      if (i == 56) drv56 = cyc;
    end
    repeat (8) drive(1'b0, 2'b00);
    for (int i = 0; i < 56 && i < n; i++) h = {h[109:0], body[i]};
    acc = h[111:64] == MAC || h[111:64] == BCAST;
    if (synced && eff >= 72) begin
      exp_dest = h[111:64];
      exp_src = h[63:16];
      exp_eth = h[15:0];
      if (acc) for (int i = 56; i <= eff - 17; i++) exp_pl.push_back(body[i]);
    end
    if (synced && abort_at < 0) begin
      for (int i = 0; i < n - 16; i++) data.push_back(body[i]);
      for (int i = (n >= 16 ? n - 16 : 0); i < n; i++) tail = {tail[29:0], body[i]};
      exp_fcs = n >= 72 && n % 4 == 0 && fcs_of(data) == tail;
    end
    if (abort_at >= 0) begin
      exp_dest = '0;
      exp_src = '0;
      exp_eth = '0;
      exp_fcs = 1'b0;
    end
    chk({tag, " header_valid count"}, 64'(hv_n), 64'(synced && eff >= 72));
    chk({tag, " frame_done count"}, 64'(done_n), 64'(synced && abort_at < 0));
    chk({tag, " payload count"}, 64'(got_pl.size()), 64'(exp_pl.size()));
    for (int i = 0; i < exp_pl.size() && i < got_pl.size(); i++)
      chk($sformatf("%s payload[%0d]", tag, i), 64'(got_pl[i]), 64'(exp_pl[i]));
    if (exp_pl.size() > 0 && got_pl.size() > 0) chk({tag, " latency"}, 64'(first_ov - drv56), 17);
    if (done_n > 0) chk({tag, " fcs_ok at frame_done"}, 64'(done_fcs), 64'(exp_fcs));
    chk({tag, " fcs_ok held"}, 64'(bus.fcs_ok), 64'(exp_fcs));
    chk({tag, " dest_mac"}, 64'(bus.dest_mac), 64'(exp_dest));
    chk({tag, " src_mac"}, 64'(bus.src_mac), 64'(exp_src));
    chk({tag, " ethertype"}, 64'(bus.ethertype), 64'(exp_eth));
  endtask

  initial begin
    dq_t good;
    dq_t f;
    bus.axiiv = 1'b0;
    bus.axiid = 2'b00;
    repeat (3) @(negedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    good = build(BCAST, BCAST, 16'h9000, words(32'hDEAD_BEEF));
    run_frame("good", 31, good, -1);
    f = good;
    f[60] = f[60] ^ 2'b01;
    run_frame("corrupt", 31, f, -1);
    run_frame("filt_miss", 12, build(48'h02_00_00_00_00_02, 48'h0A_0B_0C_0D_0E_0F, 16'h0800, words(32'h1234_5678)), -1);
    run_frame("filt_hit", 12, build(MAC, 48'h0A_0B_0C_0D_0E_0F, 16'h0800, words(32'h1234_5678)), -1);
    run_frame("runt", 31, rand_dibits(40), -1);
    f = good;
    f.push_back(2'b10);
    run_frame("extra_dibit", 31, f, -1);
    run_frame("short_pre", 5, good, -1);
    run_frame("after_short", 8, good, -1);
    run_frame("rst_mid", 31, build(BCAST, 48'h11_22_33_44_55_66, 16'h88B5, rand_dibits(64)), 96);
    run_frame("after_rst", 31, good, -1);
    for (int k = 0; k < 24; k++) begin
      int mode = $urandom_range(0, 5);
      int pre = (mode == 0) ? $urandom_range(1, 7) : $urandom_range(8, 31);
      int sel = $urandom_range(0, 2);
      logic [47:0] dest = (sel == 0) ? BCAST : (sel == 1) ? MAC : {$urandom, $urandom};
      f = (mode == 1) ? rand_dibits($urandom_range(1, 90))
                      : build(dest, {$urandom, $urandom}, 16'($urandom), rand_dibits($urandom_range(0, 60)));
      if (mode == 2) f[$urandom_range(0, f.size() - 1)] ^= 2'b10;
      run_frame($sformatf("rand%0d", k), pre, f, -1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
